// File: rtl/wd_stream_driver.sv
// wd_stream_driver: multi-stream write-data source for the stream buffer bench.
// Each stream walks elements 0..ways-1. o_d carries the stream id in its upper
// half and element+1 in its lower half, so a checker can recompute any value.
// All state advances on the falling clock edge.
module wd_stream_driver #(
    parameter int width      = 64,
    parameter int ways       = 10,
    parameter int streams    = 4,
    parameter int ways_width = $clog2(ways),
    parameter int sid_width  = (streams > 1) ? $clog2(streams) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [sid_width-1:0] i_s,
    input  logic [streams-1:0]   i_rewind,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [width-1:0]     o_d,
    output logic [sid_width-1:0] o_s,
    output logic                 o_last,
    output logic [streams-1:0]   o_done
);

    localparam int HW = width / 2;
    localparam logic [ways_width-1:0] LAST_IDX = ways_width'(ways - 1);

    logic [streams-1:0][ways_width-1:0] idx_q, idx_d;
    logic [streams-1:0]                 done_q, done_d;
    logic                               o_v_q, o_v_d;
    logic [width-1:0]                   o_d_q, o_d_d;
    logic [sid_width-1:0]               o_s_q, o_s_d;
    logic                               o_last_q, o_last_d;

    logic                  i_act;
    logic                  sid_ok;
    logic [ways_width-1:0] cur_idx;
    logic                  is_last;

    // Single-stage output register: ready whenever it is empty or draining.
    assign i_r    = ~o_v_q | o_r;
    assign i_act  = i_v & i_r;
    // Out-of-range ids read element 0 and leave every counter alone.
    assign sid_ok  = 32'(i_s) < 32'(streams);
    assign cur_idx = sid_ok ? idx_q[i_s] : '0;
    assign is_last = sid_ok && (cur_idx == LAST_IDX);

    assign o_v    = o_v_q;
    assign o_d    = o_d_q;
    assign o_s    = o_s_q;
    assign o_last = o_last_q;
    assign o_done = done_q;

    // Next-state: load on accept, drain on o_r, then apply rewinds on top.
    always_comb begin
        idx_d    = idx_q;
        done_d   = done_q;
        o_v_d    = o_v_q;
        o_d_d    = o_d_q;
        o_s_d    = o_s_q;
        o_last_d = o_last_q;
        if (i_act) begin
            o_v_d    = 1'b1;
            o_d_d    = {HW'(i_s), HW'(cur_idx) + HW'(1)};
            o_s_d    = i_s;
            o_last_d = is_last;
            if (sid_ok) begin
                if (is_last) begin
                    idx_d[i_s]  = '0;
                    done_d[i_s] = 1'b1;
                end else begin
                    idx_d[i_s] = cur_idx + ways_width'(1);
                end
            end
        end else if (o_r) begin
            o_v_d = 1'b0;
        end
        // Rewind wins over the accept's increment/done-set; the output
        // element already picked up the pre-rewind index above.
        for (int s = 0; s < streams; s++) begin
            if (i_rewind[s]) begin
                idx_d[s]  = '0;
                done_d[s] = 1'b0;
            end
        end
    end

    // Falling-edge state register with asynchronous active-low reset.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            done_q   <= '0;
            o_v_q    <= 1'b0;
            o_d_q    <= '0;
            o_s_q    <= '0;
            o_last_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            done_q   <= done_d;
            o_v_q    <= o_v_d;
            o_d_q    <= o_d_d;
            o_s_q    <= o_s_d;
            o_last_q <= o_last_d;
        end
    end

    // Flag requests for nonexistent streams in simulation.
    always_ff @(negedge clk) begin
        if (reset && i_act && !sid_ok)
            $error("wd_stream_driver: illegal stream id %0d", i_s);
    end

endmodule

// File: tb/tb_wd_stream_driver.sv
// Bench for wd_stream_driver: behavioural per-stream model checked every
// rising edge, plus directed scenarios with literal expected values.
module tb_wd_stream_driver;

    localparam int W  = 64;
    localparam int WY = 10;
    localparam int NS = 4;

    logic          clk = 1'b1;
    logic          reset = 1'b0;
    logic          i_v = 1'b0;
    logic          i_r;
    logic [1:0]    i_s = '0;
    logic [NS-1:0] i_rewind = '0;
    logic          o_v;
    logic          o_r = 1'b1;
    logic [W-1:0]  o_d;
    logic [1:0]    o_s;
    logic          o_last;
    logic [NS-1:0] o_done;

    int total = 0;
    int bad   = 0;

    wd_stream_driver #(.width(W), .ways(WY), .streams(NS)) dut (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_s(i_s),
        .i_rewind(i_rewind), .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_s(o_s),
        .o_last(o_last), .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: next element number per stream, sticky done, one output slot.
    int          nxt_m [NS];
    logic [NS-1:0] done_m = '0;
    logic        v_m = 1'b0;
    logic [63:0] d_m = '0;
    logic [1:0]  s_m = '0;
    logic        last_m = 1'b0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NS; k++) nxt_m[k] = 0;
            done_m = '0; v_m = 0; d_m = '0; s_m = '0; last_m = 0;
        end else begin
            if (i_v && (!v_m || o_r)) begin
                int e;
                e      = nxt_m[i_s];
                d_m    = (64'(i_s) << 32) + 64'(e + 1);
                s_m    = i_s;
                last_m = (e == WY - 1);
                v_m    = 1;
                nxt_m[i_s] = (e + 1) % WY;
                if (e == WY - 1) done_m[i_s] = 1'b1;
            end else if (o_r) begin
                v_m = 0;
            end
            for (int k = 0; k < NS; k++)
                if (i_rewind[k]) begin nxt_m[k] = 0; done_m[k] = 1'b0; end
        end
    end

    // Compare DUT against model on every rising edge.
    always @(posedge clk) begin
        chk("o_v",    64'(o_v),    64'(v_m));
        chk("i_r",    64'(i_r),    64'(!v_m || o_r));
        chk("o_d",    o_d,         d_m);
        chk("o_s",    64'(o_s),    64'(s_m));
        chk("o_last", 64'(o_last), 64'(last_m));
        chk("o_done", 64'(o_done), 64'(done_m));
    end

    // Drive one falling edge worth of inputs; returns just after that edge.
    task automatic cyc(input logic v, input logic [1:0] s, input logic r, input logic [NS-1:0] rw);
        i_v = v; i_s = s; o_r = r; i_rewind = rw;
        @(negedge clk); #1;
    endtask

    initial begin
        for (int k = 0; k < NS; k++) nxt_m[k] = 0;
        // Reset, then idle
        repeat (3) @(negedge clk);
        #1;
        chk("rst_o_v", 64'(o_v), 64'd0);
        chk("rst_i_r", 64'(i_r), 64'd1);
        chk("rst_o_d", o_d, 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        reset = 1'b1;
        cyc(0, 0, 1, '0);
        chk("idle_o_v", 64'(o_v), 64'd0);

        // Single-stream sweep on stream 1, including the wrap
        for (int k = 0; k < 11; k++) begin
            cyc(1, 1, 1, '0);
            chk("sweep_d", o_d, {32'd1, 32'((k % WY) + 1)});
            chk("sweep_last", 64'(o_last), 64'(k == 9));
            chk("sweep_done", 64'(o_done), (k >= 9) ? 64'h2 : 64'h0);
        end
        chk("first_elem", 64'h0000_0001_0000_0001, o_d);

        // Interleave streams 0 and 3
        cyc(1, 0, 1, '0); chk("il0", o_d, 64'h0000_0000_0000_0001);
        cyc(1, 3, 1, '0); chk("il1", o_d, 64'h0000_0003_0000_0001);
        cyc(1, 0, 1, '0); chk("il2", o_d, 64'h0000_0000_0000_0002);
        cyc(1, 3, 1, '0); chk("il3", o_d, 64'h0000_0003_0000_0002);
        cyc(1, 0, 1, '0); chk("il4", o_d, 64'h0000_0000_0000_0003);
        chk("il_s", 64'(o_s), 64'd0);

        // Back-pressure: element 4 of stream 0 held for 4 cycles
        cyc(1, 0, 1, '0); chk("bp_load", o_d, 64'h0000_0000_0000_0004);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, '0);
            chk("bp_i_r", 64'(i_r), 64'd0);
            chk("bp_hold", o_d, 64'h0000_0000_0000_0004);
            chk("bp_v", 64'(o_v), 64'd1);
        end
        cyc(1, 0, 1, '0); chk("bp_resume", o_d, 64'h0000_0000_0000_0005);
        cyc(1, 0, 1, '0); chk("bp_next", o_d, 64'h0000_0000_0000_0006);
        cyc(0, 0, 1, '0); chk("drain_v", 64'(o_v), 64'd0);

        // Rewind colliding with the last element of stream 2
        for (int k = 0; k < 9; k++) cyc(1, 2, 1, '0);
        chk("rw_pre", o_d, 64'h0000_0002_0000_0009);
        cyc(1, 2, 1, 4'b0100);
        chk("rw_d", o_d, 64'h0000_0002_0000_000A);
        chk("rw_last", 64'(o_last), 64'd1);
        chk("rw_done", 64'(o_done), 64'h2);
        cyc(1, 2, 1, '0);
        chk("rw_after", o_d, 64'h0000_0002_0000_0001);

        // Asynchronous reset while an element is held under back-pressure
        cyc(1, 0, 1, '0); chk("ar_load", o_d, 64'h0000_0000_0000_0007);
        i_v = 0; o_r = 0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("ar_o_v", 64'(o_v), 64'd0);
        chk("ar_o_d", o_d, 64'd0);
        chk("ar_done", 64'(o_done), 64'd0);
        chk("ar_i_r", 64'(i_r), 64'd1);
        @(negedge clk); @(negedge clk); #1;
        reset = 1'b1;
        cyc(1, 0, 1, '0); chk("ar_restart", o_d, 64'h0000_0000_0000_0001);
        cyc(0, 0, 1, '0);
        cyc(0, 0, 1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
